// File: rtl/vram_arbiter_pkg.sv
// Shared types and width defaults for the video RAM arbiter slice.
package vram_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_GPU = 1'b1
    } owner_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of CPU, GPU and RAM-port signals around the arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic                  CPUReq;
    logic                  CPUWrite;
    logic [ADDR_W-1:0]     CPUAddress;
    logic [DATA_W-1:0]     CPUWriteData;
    logic [DATA_W/8-1:0]   CPUByteEnable;
    logic                  CPUGrant;
    logic [DATA_W-1:0]     CPUReadData;
    logic                  CPUReadValid;

    logic                  GPUReq;
    logic [ADDR_W-1:0]     GPUAddress;
    logic                  GPUGrant;
    logic [DATA_W-1:0]     GPUData;
    logic                  GPUDataValid;

    logic                  MemEnable;
    logic                  MemWrite;
    logic [ADDR_W-1:0]     MemAddress;
    logic [DATA_W-1:0]     MemWriteData;
    logic [DATA_W/8-1:0]   MemByteEnable;
    logic [DATA_W-1:0]     MemReadData;

    modport slave (
        input  CPUReq, CPUWrite, CPUAddress, CPUWriteData, CPUByteEnable,
        output CPUGrant, CPUReadData, CPUReadValid,
        input  GPUReq, GPUAddress,
        output GPUGrant, GPUData, GPUDataValid,
        output MemEnable, MemWrite, MemAddress, MemWriteData, MemByteEnable,
        input  MemReadData
    );

    modport master (
        output CPUReq, CPUWrite, CPUAddress, CPUWriteData, CPUByteEnable,
        input  CPUGrant, CPUReadData, CPUReadValid,
        output GPUReq, GPUAddress,
        input  GPUGrant, GPUData, GPUDataValid,
        input  MemEnable, MemWrite, MemAddress, MemWriteData, MemByteEnable,
        output MemReadData
    );

endinterface

// File: rtl/vram_arbiter_return_pipe.sv
// Read-return tracking: tag stage 1 covers the issue cycle, stage 2 the
// cycle RAM data is on the bus; data is then registered to its owner.
module vram_return_pipe
    import vram_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              issue_valid,
    input  owner_t            issue_owner,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] gpu_data,
    output logic              gpu_valid
);

    logic   s1_valid;
    owner_t s1_owner;
    logic   s2_valid;
    owner_t s2_owner;

    // Advance tags each cycle; owner only loads with a live tag so it stays stable in flight.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            s1_valid  <= 1'b0;
            s1_owner  <= OWNER_CPU;
            s2_valid  <= 1'b0;
            s2_owner  <= OWNER_CPU;
            cpu_valid <= 1'b0;
            cpu_data  <= '0;
            gpu_valid <= 1'b0;
            gpu_data  <= '0;
        end else begin
            s1_valid <= issue_valid;
            if (issue_valid) s1_owner <= issue_owner;
            s2_valid <= s1_valid;
            if (s1_valid) s2_owner <= s1_owner;

            cpu_valid <= s2_valid && (s2_owner == OWNER_CPU);
            gpu_valid <= s2_valid && (s2_owner == OWNER_GPU);
            if (s2_valid && (s2_owner == OWNER_CPU)) cpu_data <= mem_rdata;
            if (s2_valid && (s2_owner == OWNER_GPU)) gpu_data <= mem_rdata;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Two-requester VRAM arbiter: GPU scanout normally wins, but the CPU is
// forced through after STARVE_LIMIT consecutive losses.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            Clock,
    input  logic            ResetN,
    vram_arbiter_if.slave   bus
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam logic [2:0]  LIMIT = 3'(STARVE_LIMIT);

    state_t              state;
    logic [2:0]          starve;
    logic                gpu_win;
    logic                cpu_win;
    logic                issue_valid;
    owner_t              issue_owner;

    logic                cpu_grant;
    logic                gpu_grant;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [BE_W-1:0]     mem_be;

    logic [DATA_W-1:0]   cpu_data;
    logic                cpu_valid;
    logic [DATA_W-1:0]   gpu_data;
    logic                gpu_valid;

    // Winner selection and read-issue tag for the current IDLE cycle.
    always_comb begin
        gpu_win     = bus.GPUReq && (!bus.CPUReq || (starve < LIMIT));
        cpu_win     = bus.CPUReq && !gpu_win;
        issue_valid = (state == IDLE) && (gpu_win || (cpu_win && !bus.CPUWrite));
        issue_owner = gpu_win ? OWNER_GPU : OWNER_CPU;
    end

    // Two-state FSM with registered grant and RAM-port outputs.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state     <= IDLE;
            starve    <= '0;
            cpu_grant <= 1'b0;
            gpu_grant <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            cpu_grant <= 1'b0;
            gpu_grant <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            case (state)
                IDLE: begin
                    if (gpu_win) begin
                        state     <= GRANT;
                        gpu_grant <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_addr  <= bus.GPUAddress;
                    end else if (cpu_win) begin
                        state     <= GRANT;
                        cpu_grant <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= bus.CPUWrite;
                        mem_addr  <= bus.CPUAddress;
                        mem_wdata <= bus.CPUWrite ? bus.CPUWriteData : '0;
                        mem_be    <= bus.CPUWrite ? bus.CPUByteEnable : '1;
                    end
                    if (bus.CPUReq && gpu_win) begin
                        if (starve < LIMIT) starve <= starve + 3'd1;
                    end else begin
                        starve <= '0;
                    end
                end
                GRANT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    vram_return_pipe #(
        .DATA_W (DATA_W)
    ) u_return_pipe (
        .Clock       (Clock),
        .ResetN      (ResetN),
        .issue_valid (issue_valid),
        .issue_owner (issue_owner),
        .mem_rdata   (bus.MemReadData),
        .cpu_data    (cpu_data),
        .cpu_valid   (cpu_valid),
        .gpu_data    (gpu_data),
        .gpu_valid   (gpu_valid)
    );

    assign bus.CPUGrant      = cpu_grant;
    assign bus.GPUGrant      = gpu_grant;
    assign bus.MemEnable     = mem_en;
    assign bus.MemWrite      = mem_we;
    assign bus.MemAddress    = mem_addr;
    assign bus.MemWriteData  = mem_wdata;
    assign bus.MemByteEnable = mem_be;
    assign bus.CPUReadData   = cpu_data;
    assign bus.CPUReadValid  = cpu_valid;
    assign bus.GPUData       = gpu_data;
    assign bus.GPUDataValid  = gpu_valid;

endmodule
